// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle control FSM for the RV32 subset datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB from the decoded opcode/funct3/funct7
// fields, drives the datapath enables, ALU op and memory handshake, and
// counts retired instructions.
// Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, an
// unsupported instruction parks the FSM in TRAP until reset. When it is not
// defined, an unsupported instruction retires as a NOP.
module multicycle_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_sel,
  output logic                 reg_write,
  output logic                 wb_sel,
  output logic                 alu_src_b,
  output logic [3:0]           alu_op,
  output logic [2:0]           state,
  output logic                 trap,
  output logic [CNT_WIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SLT = 4'd7
  } alu_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                fsm_state;
  logic [CNT_WIDTH-1:0]  instret_q;

  logic is_r, is_i, is_lw, is_sw, is_br;
  logic arith_ok;
  alu_t arith_op;
  logic exec_alu, exec_mem, exec_br;
  logic br_take;

  // Only funct7[5] (SUB select) carries meaning in this subset.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Instruction classification and ALU function decode from the IR fields.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    arith_ok = 1'b1;
    arith_op = ALU_ADD;
    is_r     = (opcode == OP_R);
    is_i     = (opcode == OP_I);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_br    = (opcode == OP_BR);
    case (funct3)
      3'b000:  arith_op = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  arith_op = ALU_AND;
      3'b110:  arith_op = ALU_OR;
      3'b100:  arith_op = ALU_XOR;
      3'b001:  arith_op = ALU_SLL;
      3'b101:  arith_op = ALU_SRL;
      3'b010:  arith_op = ALU_SLT;
      default: arith_ok = 1'b0;
    endcase
    exec_alu = (is_r || is_i) && arith_ok;
    exec_mem = (is_lw || is_sw) && (funct3 == 3'b010);
    exec_br  = is_br && ((funct3 == 3'b000) || (funct3 == 3'b001));
    br_take  = ((funct3 == 3'b000) && alu_zero) ||
               ((funct3 == 3'b001) && !alu_zero);
  end

  // Datapath strobes decoded from the current state and decode fields;
  // a cycle with reset asserted issues no strobe at all.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    if (!reset) begin
      case (fsm_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC: begin
          if (exec_alu) begin
            alu_src_b = is_i;
            alu_op    = arith_op;
          end else if (exec_mem) begin
            alu_src_b = 1'b1;
            alu_op    = ALU_ADD;
          end else if (exec_br) begin
            alu_op   = ALU_SUB;
            pc_write = br_take;
            pc_sel   = br_take;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = is_sw;
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_sel    = is_lw;
        end
        default: ;
      endcase
    end
  end

  // State sequencing and retired-instruction count.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      fsm_state <= S_FETCH;
      instret_q <= '0;
    end else begin
      case (fsm_state)
        S_FETCH: if (mem_ready) fsm_state <= S_DECODE;
        S_DECODE: fsm_state <= S_EXEC;
        S_EXEC: begin
          if (exec_alu) begin
            fsm_state <= S_WB;
          end else if (exec_mem) begin
            fsm_state <= S_MEM;
          end else if (exec_br) begin
            fsm_state <= S_FETCH;
            instret_q <= instret_q + CNT_ONE;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            fsm_state <= S_TRAP;
`else
            fsm_state <= S_FETCH;
            instret_q <= instret_q + CNT_ONE;
`endif
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_sw) begin
              fsm_state <= S_FETCH;
              instret_q <= instret_q + CNT_ONE;
            end else begin
              fsm_state <= S_WB;
            end
          end
        end
        S_WB: begin
          fsm_state <= S_FETCH;
          instret_q <= instret_q + CNT_ONE;
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP: fsm_state <= S_TRAP;
`endif
        default: fsm_state <= S_FETCH;
      endcase
    end
  end

  assign state   = fsm_state;
  assign instret = instret_q;

`ifdef ILLEGAL_TRAP_EN
  assign trap = (fsm_state == S_TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule
